store_merge_unit: RTL

Store-side counterpart of the datapath's load extraction logic. Accepts a store request (word, halfword or byte) from the multicycle controller and performs it on a word-only data memory with no byte enables. Sub-word stores use read-modify-write; word stores write directly. Sits between the datapath store path (ALUOut address, rt data) and the data memory port.

---
 rtl/store_merge_unit_pkg.sv | 27 ++
 rtl/store_merge_unit_lane.sv | 41 ++++
 rtl/store_merge_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/store_merge_unit_pkg.sv
// Shared load/store type codes and store merge FSM encodings.
// Optional misaligned-store fault: STORE_MISALIGN_EXC_EN.
package store_merge_unit_pkg;

    localparam logic [2:0] LoadWord      = 3'd0;
    localparam logic [2:0] LoadHalfWord  = 3'd1;
    localparam logic [2:0] LoadHalfWordU = 3'd2;
    localparam logic [2:0] LoadByte      = 3'd3;
    localparam logic [2:0] LoadByteU     = 3'd4;

    localparam logic [2:0] StoreWord     = 3'd0;
    localparam logic [2:0] StoreHalfWord = 3'd1;
    localparam logic [2:0] StoreByte     = 3'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } smu_state_e;

    function automatic logic is_subword(input logic [2:0] t);
        return (t == StoreHalfWord) || (t == StoreByte);
    endfunction

endpackage

// File: rtl/store_merge_unit_lane.sv
// Combinational byte/halfword lane merge into an old memory word.
// Unknown store types behave as word stores.
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [31:0] old,
    input  logic [31:0] StoreData,
    input  logic [2:0]  StoreType,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    logic [7:0] b;
    logic [15:0] h;

    assign b = StoreData[7:0];
    assign h = StoreData[15:0];

    always_comb begin
        merged = StoreData;
        unique case (1'b1)
            (StoreType == StoreByte): begin
                unique case (offset)
                    2'd0:    merged = {old[31:8], b};
                    2'd1:    merged = {old[31:16], b, old[7:0]};
                    2'd2:    merged = {old[31:24], b, old[15:0]};
                    default: merged = {b, old[23:0]};
                endcase
            end
            (StoreType == StoreHalfWord): begin
                // Only offset[1] selects the half; offset[0] is ignored here.
                if (offset[1])
                    merged = {h, old[15:0]};
                else
                    merged = {old[31:16], h};
            end
            default: merged = StoreData;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store unit for a word-only memory: read-modify-write for sub-word stores.
// Optional misaligned-store fault: STORE_MISALIGN_EXC_EN.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [2:0]        StoreType,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       StoreData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRdEn,
    input  logic [31:0]       MemRdData,
    input  logic              MemRdValid,
    output logic              MemWrEn,
    output logic [31:0]       MemWrData,
    input  logic              MemWrAck
);

    smu_state_e state_q, state_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [31:0]       merged;

`ifdef STORE_MISALIGN_EXC_EN
    logic error_q, error_d;
    logic misalign;

    always_comb begin
        if (StoreType == StoreHalfWord)
            misalign = Addr[0];
        else if (StoreType == StoreByte)
            misalign = 1'b0;
        else
            misalign = (Addr[1:0] != 2'b00);
    end
`endif

    store_lane_merge u_merge (
        .old       (MemRdData),
        .StoreData (data_q),
        .StoreType (type_q),
        .offset    (off_q),
        .merged    (merged)
    );

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        off_d     = off_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        addr_d    = addr_q;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
`ifdef STORE_MISALIGN_EXC_EN
        error_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    type_d = StoreType;
                    off_d  = Addr[1:0];
                    data_d = StoreData;
                    addr_d = {Addr[ADDR_W-1:2], 2'b00};
                    busy_d = 1'b1;
`ifdef STORE_MISALIGN_EXC_EN
                    if (misalign) begin
                        state_d = FAULT;
                    end else
`endif
                    if (is_subword(StoreType)) begin
                        state_d = READ;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_data_d = StoreData;
                    end
                end
            end
            READ: begin
                if (MemRdValid) begin
                    state_d   = WRITE;
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b1;
                    wr_data_d = merged;
                end
            end
            WRITE: begin
                if (MemWrAck) begin
                    state_d = DONE;
                    wr_en_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef STORE_MISALIGN_EXC_EN
            FAULT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                error_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            type_q    <= StoreWord;
            off_q     <= 2'b00;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            off_q     <= off_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef STORE_MISALIGN_EXC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            error_q <= 1'b0;
        else
            error_q <= error_d;
    end

    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign MemAddr   = addr_q;
    assign MemRdEn   = rd_en_q;
    assign MemWrEn   = wr_en_q;
    assign MemWrData = wr_data_q;

endmodule
